// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input
// in prescaled ticks. Optional glitch filter: define PWM_CAPTURE_FILTER_EN.
module pwm_capture (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in,
  input  logic        en,
  input  logic        capture_reset,
  input  logic [7:0]  prescale,
  output logic [15:0] meas_period,
  output logic [15:0] meas_high,
  output logic        valid,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q, prev_q;
  logic        lvl, rise, fall;
  logic [7:0]  pcnt_q, pcnt_d;
  logic [15:0] timer_q, timer_d, timer_inc;
  logic        sat_q, sat_d;
  logic [15:0] high_lat_q, high_lat_d;
  logic [15:0] mp_q, mp_d, mh_q, mh_d;
  logic        valid_q, valid_d, ovf_q, ovf_d;
  logic        active, counting, tick, sat_tick, restart, latch_high, publish;

`ifdef PWM_CAPTURE_FILTER_EN
  // Filtered level follows the synchronizer only once three consecutive
  // samples agree; combinational output keeps added latency at 2 clocks.
  logic hist1_q, hist2_q, filt_q, filt_d;

  // glitch filter decision
  always_comb begin
    filt_d = filt_q;
    if ((sync2_q == hist1_q) && (hist1_q == hist2_q)) filt_d = sync2_q;
  end

  // filter history and held level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist1_q <= 1'b0;
      hist2_q <= 1'b0;
      filt_q  <= 1'b0;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
      filt_q  <= filt_d;
    end
  end

  assign lvl = filt_d;
`else
  assign lvl = sync2_q;
`endif

  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; software clear and enable dominate edges
  always_comb begin
    state_d = state_q;
    if (capture_reset)   state_d = en ? ARM : IDLE;
    else if (!en)        state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    state_d = ARM;
        ARM:     if (rise) state_d = HIGH;
        HIGH:    if (fall) state_d = LOW;
        LOW:     if (rise) state_d = HIGH;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM output decode: tick, restart, latch and publish strobes
  always_comb begin
    active     = en && !capture_reset;
    counting   = (state_q != IDLE);
    tick       = counting && (pcnt_q == prescale);
    sat_tick   = tick && (timer_q == 16'hFFFF);
    timer_inc  = (tick && !sat_tick) ? timer_q + 16'd1 : timer_q;
    restart    = active && rise && ((state_q == ARM) || (state_q == LOW));
    latch_high = active && fall && (state_q == HIGH);
    // a saturated interval (including a saturating tick on the edge itself) is dropped
    publish    = active && rise && (state_q == LOW) && !(sat_q || sat_tick);
  end

  // datapath next values: timebase, timer, latches and published results
  always_comb begin
    pcnt_d     = tick ? 8'd0 : pcnt_q + 8'd1;
    timer_d    = timer_inc;
    sat_d      = sat_q | sat_tick;
    high_lat_d = latch_high ? timer_inc : high_lat_q;
    mp_d       = mp_q;
    mh_d       = mh_q;
    valid_d    = 1'b0;
    ovf_d      = ovf_q | sat_tick;
    if (publish) begin
      mp_d    = timer_inc;
      mh_d    = high_lat_q;
      valid_d = 1'b1;
    end
    if (restart || !active || !counting) begin
      pcnt_d  = 8'd0;
      timer_d = 16'd0;
      sat_d   = 1'b0;
    end
    if (capture_reset) begin
      high_lat_d = 16'd0;
      mp_d       = 16'd0;
      mh_d       = 16'd0;
      ovf_d      = 1'b0;
    end
  end

  // synchronizer, edge history and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      pcnt_q     <= 8'd0;
      timer_q    <= 16'd0;
      sat_q      <= 1'b0;
      high_lat_q <= 16'd0;
      mp_q       <= 16'd0;
      mh_q       <= 16'd0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sync1_q    <= pwm_in;
      sync2_q    <= sync1_q;
      prev_q     <= lvl;
      pcnt_q     <= pcnt_d;
      timer_q    <= timer_d;
      sat_q      <= sat_d;
      high_lat_q <= high_lat_d;
      mp_q       <= mp_d;
      mh_q       <= mh_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign meas_period = mp_q;
  assign meas_high   = mh_q;
  assign valid       = valid_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed + randomized bench for pwm_capture; expected results are computed
// from the waveform segment lengths with integer division by (prescale+1).
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst_n, pwm_in, en, capture_reset;
  logic [7:0]  prescale;
  logic [15:0] meas_period, meas_high;
  logic        valid, overflow;

  int n_assert = 0;
  int n_fail   = 0;

  int unsigned exp_p[$], exp_h[$], obs_p[$], obs_h[$];

  pwm_capture dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .en(en),
    .capture_reset(capture_reset), .prescale(prescale),
    .meas_period(meas_period), .meas_high(meas_high),
    .valid(valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // record every published result, sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid === 1'b1) begin
      obs_p.push_back(meas_period);
      obs_h.push_back(meas_high);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // hold pwm_in at a level for n clocks; returns 1 time unit after a rising clk edge
  task automatic seg(input logic l, input int n);
    pwm_in = l;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // abandon any measurement, set prescale, arm with pwm low
  task automatic start(input int p);
    pwm_in = 1'b0;
    en     = 1'b0;
    seg(1'b0, 4);
    prescale = 8'(p);
    en       = 1'b1;
    seg(1'b0, 6);
  endtask

  // n periods; first rise arms, each following rise publishes the previous period
  task automatic run(input int p, input int n, input int hi_f, input int lo_f, input bit rnd);
    int hi, lo;
    for (int i = 0; i < n; i++) begin
      hi = rnd ? int'($urandom_range(5, 60)) : hi_f;
      lo = rnd ? int'($urandom_range(5, 60)) : lo_f;
      seg(1'b1, hi);
      seg(1'b0, lo);
      exp_p.push_back((hi + lo) / (p + 1));
      exp_h.push_back(hi / (p + 1));
    end
    seg(1'b1, 12);
  endtask

  task automatic check_pubs(input string tag);
    chk({tag, " count"}, obs_p.size(), exp_p.size());
    for (int i = 0; i < exp_p.size() && i < obs_p.size(); i++) begin
      chk($sformatf("%s period[%0d]", tag, i), obs_p[i], exp_p[i]);
      chk($sformatf("%s high[%0d]", tag, i), obs_h[i], exp_h[i]);
    end
    chk({tag, " valid idle"}, valid, 0);
    exp_p.delete(); exp_h.delete(); obs_p.delete(); obs_h.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " period"},   meas_period, 0);
    chk({tag, " high"},     meas_high, 0);
    chk({tag, " valid"},    valid, 0);
    chk({tag, " overflow"}, overflow, 0);
  endtask

  initial begin
    int p;
    rst_n = 1'b0; pwm_in = 1'b0; en = 1'b0; capture_reset = 1'b0; prescale = 8'd0;
    #23;
    chk_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 100-clk period, 30 high, prescale 0
    start(0);
    run(0, 5, 30, 70, 1'b0);
    chk("basic last period", meas_period, 100);
    check_pubs("basic");

    // prescale 3, 400/100
    start(3);
    run(3, 3, 100, 300, 1'b0);
    check_pubs("pre3");

    // randomized periods and prescales
    for (int t = 0; t < 4; t++) begin
      p = int'($urandom_range(0, 5));
      start(p);
      run(p, 4, 0, 0, 1'b1);
      check_pubs($sformatf("rand%0d", t));
    end
    chk("no overflow yet", overflow, 0);

    // prescale change mid-interval: next clean interval must measure correctly
    start(0);
    seg(1'b1, 20);
    prescale = 8'd7;
    seg(1'b0, 40);
    seg(1'b1, 16);
    obs_p.delete(); obs_h.delete();
    seg(1'b0, 48);
    exp_p.push_back(64 / 8); exp_h.push_back(16 / 8);
    seg(1'b1, 12);
    check_pubs("prescale change");

    // en dropped mid-period, then re-raised
    start(0);
    run(0, 2, 40, 60, 1'b0);
    check_pubs("pre-drop");
    seg(1'b1, 28);
    seg(1'b0, 20);
    en = 1'b0;
    seg(1'b0, 40);
    seg(1'b1, 40);
    seg(1'b0, 60);
    seg(1'b1, 10);
    check_pubs("en low");
    chk("retained period", meas_period, 100);
    chk("retained high", meas_high, 40);
    seg(1'b1, 30);
    seg(1'b0, 30);
    en = 1'b1;
    seg(1'b0, 30);
    seg(1'b1, 25);
    seg(1'b0, 55);
    exp_p.push_back(80); exp_h.push_back(25);
    seg(1'b1, 12);
    check_pubs("en re-raised");

    // 2-clk glitch inside the low phase
    start(0);
    seg(1'b1, 30);
    seg(1'b0, 20);
    seg(1'b1, 2);
    seg(1'b0, 48);
    seg(1'b1, 30);
    seg(1'b0, 70);
    seg(1'b1, 12);
`ifdef PWM_CAPTURE_FILTER_EN
    exp_p.push_back(100); exp_h.push_back(30);
    exp_p.push_back(100); exp_h.push_back(30);
`else
    exp_p.push_back(50);  exp_h.push_back(30);
    exp_p.push_back(50);  exp_h.push_back(2);
    exp_p.push_back(100); exp_h.push_back(30);
`endif
    check_pubs("glitch");

    // timer saturation: interval dropped, sticky flag, FSM keeps going
    start(0);
    seg(1'b1, 65600);
    chk("overflow set", overflow, 1);
    seg(1'b0, 20);
    seg(1'b1, 30);
    seg(1'b0, 70);
    exp_p.push_back(100); exp_h.push_back(30);
    seg(1'b1, 12);
    check_pubs("saturation");
    chk("overflow sticky", overflow, 1);
    capture_reset = 1'b1;
    @(posedge clk); #1;
    capture_reset = 1'b0;
    chk_zero("capture_reset");

    // async reset in HIGH, then normal operation
    start(0);
    run(0, 1, 50, 50, 1'b0);
    check_pubs("pre-rst");
    seg(1'b1, 10);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst mid-high");
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    start(2);
    run(2, 2, 33, 66, 1'b0);
    check_pubs("post-rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
